// File: rtl/peripheral_spram_wb_responder.sv
// Wishbone B3 responder over a byte-lane single-port RAM with error decode.
// Build option PERIPHERAL_WB_BURST_EN adds registered-feedback CTI/BTE burst streaming.
module peripheral_spram_wb_responder #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_SIZE = 256
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  // state   | meaning
  // IDLE    | no beat pending; next cyc&stb is a first beat
  // CLASSIC | single acked beat, commits on this edge if still requested
  // BURST   | streaming beats, ack held while cti stays incrementing
  // ERR     | one-cycle error termination, dat_o forced to zero
  typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERR} state_t;

  localparam int AB    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            ack_d, err_d;
  logic [DW-1:0]   dat_d;
  logic [DW-1:0]   mem [WORDS];
  logic            req;
  logic            unused_ok;

  function automatic logic oor(input logic [AW-1:0] a);
    return a[AW-1:AB] != '0;
  endfunction

  function automatic logic [AB-3:0] widx(input logic [AW-1:0] a);
    return a[AB-1:2];
  endfunction

  assign req       = wb_cyc_i & wb_stb_i;
  assign unused_ok = ^{wb_adr_i[1:0], wb_cti_i, wb_bte_i, adr_q};

`ifdef PERIPHERAL_WB_BURST_EN
  logic [AW-1:0] nxt;

  // Wrap modes only roll the low word-index bits; upper bits are held.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] n;
    n = a;
    case (bte)
      2'b00:   n = a + AW'(4);
      2'b01:   n[3:2] = a[3:2] + 2'd1;
      2'b10:   n[4:2] = a[4:2] + 3'd1;
      default: n[5:2] = a[5:2] + 4'd1;
    endcase
    return n;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = wb_dat_o;
`ifdef PERIPHERAL_WB_BURST_EN
    nxt     = next_adr(adr_q, wb_bte_i);
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (oor(wb_adr_i)) begin
            state_d = ERR;
            err_d   = 1'b1;
            dat_d   = '0;
          end else begin
            ack_d = 1'b1;
            adr_d = wb_adr_i;
            dat_d = mem[widx(wb_adr_i)];
`ifdef PERIPHERAL_WB_BURST_EN
            state_d = (wb_cti_i == 3'b010) ? BURST : CLASSIC;
`else
            state_d = CLASSIC;
`endif
          end
        end
      end
      CLASSIC: state_d = IDLE;
      ERR: begin
        state_d = IDLE;
        dat_d   = '0;
      end
`ifdef PERIPHERAL_WB_BURST_EN
      BURST: begin
        if (req && wb_cti_i == 3'b010) begin
          if (oor(nxt)) begin
            state_d = ERR;
            err_d   = 1'b1;
            dat_d   = '0;
          end else begin
            ack_d = 1'b1;
            adr_d = nxt;
            dat_d = mem[widx(nxt)];
          end
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      wb_dat_o <= dat_d;
    end
  end

  // Storage is not reset; an acked beat commits only while cyc&stb still hold.
  always_ff @(posedge wb_clk_i) begin
    if (req && wb_ack_o && wb_we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wb_sel_i[b]) mem[widx(adr_q)][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/peripheral_spram_wb_responder.md
Name: peripheral_spram_wb_responder

Overview:
- Wishbone B3 slave (responder) wrapping a single-port RAM of MEM_SIZE bytes. It is the far end of the bus driven by the Wishbone BFM initiator.
- Supports classic cycles and registered-feedback incrementing bursts (CTI/BTE).
- Flags out-of-range addresses with err_o.
- Sits between the bus interconnect and the local SPRAM storage in the peripheral subsystem.

Parameters:
AW, 32, address bus width (byte address)
DW, 32, data bus width; fixed at 32 for this block
MEM_SIZE, 256, memory size in bytes; power of two, ≥16; gives MEM_SIZE/4 words

Ports:
wb_clk_i  input  1  bus clock; all logic rising-edge
wb_rst_ni  input  1  reset, asynchronous, active-low
wb_adr_i  input  AW  byte address
wb_dat_i  input  DW  write data
wb_sel_i  input  DW/8  byte-lane enables
wb_we_i  input  1  1=write, 0=read
wb_cyc_i  input  1  bus cycle valid
wb_stb_i  input  1  strobe / beat valid
wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
wb_bte_i  input  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
wb_dat_o  output  DW  read data
wb_ack_o  output  1  normal beat termination
wb_err_o  output  1  error beat termination

Behaviour:
- Reset (wb_rst_ni=0, asynchronous): wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM=IDLE, burst address register=0. RAM contents are not reset.
- Address decode:
  - Word index = adr[log2(MEM_SIZE)-1:2]; adr[1:0] ignored.
  - Out-of-range if any of adr[AW-1:log2(MEM_SIZE)] is nonzero.
- Beat commit: on a rising edge with cyc&stb&ack all 1. For a write, byte lanes with sel=1 are written with dat_i at the current address; other lanes are untouched. No write ever occurs on an err beat or with cyc=0.
- FSM states: IDLE, CLASSIC, BURST, ERR.
  - IDLE: on cyc&stb:
    - Out-of-range → ERR (err_o=1 next cycle).
    - Otherwise → CLASSIC if cti≠010, else BURST; ack_o=1 next cycle; dat_o=mem[word].
  - First-beat latency is 1 cycle (ack_o registered).
  - CLASSIC: ack_o high exactly one cycle, then → IDLE with ack_o=0. Back-to-back classic accesses therefore take 2 cycles each.
  - ERR: err_o high exactly one cycle, dat_o=0, then → IDLE.
  - BURST: each cycle with cyc&stb&ack and cti=010:
    - Next address = current address advanced by one word per BTE. Linear: +1 word. Wrap-4/8/16: increment adr[3:2]/[4:2]/[5:2] modulo 4/8/16, upper bits held.
    - ack_o stays high and dat_o = mem[next] on the following cycle (zero-wait streaming).
    - If the next address is out-of-range: ack_o=0, err_o=1 for that beat, then → IDLE.
  - Burst termination in BURST:
    - cti=111 beat completes → ack_o=0 next cycle → IDLE.
    - stb=0 or cyc=0 while in BURST → ack_o=0 next cycle → IDLE. No commit happens for a beat with cyc=0.
    - A later stb restarts as a new first beat with 1-cycle latency.
  - Simultaneous events: cyc drop in the same cycle as ack=1 means the beat is not committed. A new request arriving in the cycle ack falls is accepted from IDLE on the next edge.
- Read data is registered. dat_o holds its last value when ack_o=0, except that ERR forces it to 0.
- Reset mid-burst:
  - Outputs clear immediately.
  - Beats committed before reset persist in RAM.
  - An in-flight uncommitted beat is discarded.

Optional Feature:
PERIPHERAL_WB_BURST_EN
- Defined: BURST state and BTE address generator present, as described above.
- Undefined: cti_i/bte_i ignored. Every access is handled as CLASSIC (1-cycle latency, ack every other cycle at most). A burst-issuing master still completes correctly via its own address sequence.

Test Plan:
1. Classic write 0xDEADBEEF to 0x10, sel=1111, then classic read 0x10 → ack_o 1 cycle after stb each time, ack_o low between accesses, read dat_o=0xDEADBEEF.
2. Write 0x0000AA00 to 0x10 with sel=0010, then read 0x10 → 0xDEADAAEF.
3. Burst write (BURST_EN) from 0x18, bte=01, data 1,2,3,4, cti 010,010,010,111 → four consecutive ack cycles starting 1 cycle after stb. Readback: 0x18=1, 0x1C=2, 0x10=3, 0x14=4. Without macro: same memory result, acks non-consecutive.
4. Read 0x100 → err_o=1 for 1 cycle, ack_o=0, dat_o=0. Write 0x55 to 0x100 → err_o, and 0x00 is unchanged.
5. Linear burst read from 0xF8, 3 beats → ack for 0xF8 and 0xFC, err_o on third beat, FSM back in IDLE; next classic read of 0x00 acked normally.
6. Assert wb_rst_ni=0 mid-way through a 4-beat write burst after 2 committed beats → ack_o/err_o drop asynchronously. After release, reads return the 2 committed words; the other targets keep their old values.
